spart_echo_driver: RTL and testbench
====================================

Name: spart_echo_driver

Overview:
- Processor-side bus master for the SPART serial block. Generalised successor of the fixed-function SPART driver.
- After reset, and on every `br_cfg` change, it loads a 16-bit baud divisor over the tri-state I/O bus.
- It then echoes received bytes back to the transmitter through an internal FIFO of configurable depth.
- An optional upper-case translation mode is provided. The block sits between the board switches and the SPART I/O port.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; used for divisor computation at elaboration.
- DEPTH, 8, echo FIFO depth in bytes; power of two, 2..256.
- CNT_W, 4, width of `fifo_count`; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- mode  in  1  0=plain echo, 1=upper-case echo
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- iocs  out  1  bus chip select, high during an access cycle
- iorw  out  1  1=read from SPART, 0=write to SPART
- ioaddr  out  2  00=TX/RX buffer, 01=status (unused), 10=divisor low, 11=divisor high
- databus  inout  8  driven only when iocs=1 and iorw=0, else high-Z
- fifo_count  out  CNT_W  current FIFO occupancy
- busy  out  1  high while a divisor load is in progress

Behaviour:

Reset:
- Clock is `clk`; reset is synchronous and active-high (`rst`), sampled on the rising edge of `clk`.
- While `rst` is high, at every edge:
  - iocs=0, iorw=1, ioaddr=00, databus=Z, fifo_count=0, busy=1.
  - FIFO is emptied.
  - br_cfg_q <= br_cfg.
  - state <= LOAD_LO.
  - last_rd <= 0.
- Reset asserted mid-access aborts the access; no partial FIFO update.

Divisor:
- DIV(b) = CLK_HZ/(16*b) - 1, integer truncation, 16 bits, constant per `br_cfg` code.
- At 100 MHz: 1301 (0x0515), 650 (0x028A), 324 (0x0144), 161 (0x00A1).

States and transitions (one bus access per cycle; outputs registered):
- LOAD_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV(br_cfg_q)[7:0], busy=1 -> LOAD_HI.
- LOAD_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV(br_cfg_q)[15:8], busy=1 -> GAP.
- GAP: iocs=0, busy=0. Mandatory one idle cycle after every access so SPART `rda`/`tbr` can update -> IDLE.
- IDLE: iocs=0. Evaluated in priority order:
  1. br_cfg != br_cfg_q: br_cfg_q <= br_cfg -> LOAD_LO. FIFO contents are preserved.
  2. Read and write both eligible: read if last_rd=0, write if last_rd=1 (alternate).
  3. Otherwise, do whichever single access is eligible.
  4. Otherwise, stay in IDLE.
  - Read eligible: rda=1 and FIFO not full.
  - Write eligible: tbr=1 and FIFO not empty.
- RD: iocs=1, iorw=1, ioaddr=00, databus=Z.
  - databus is sampled at the closing edge and pushed to the FIFO.
  - last_rd <= 1 -> GAP.
- WR: iocs=1, iorw=0, ioaddr=00, databus = FIFO head, translated.
  - FIFO head is popped at the closing edge.
  - last_rd <= 0 -> GAP.

Translation:
- Applied on WR only.
- If mode=1 and byte is in 0x61..0x7A, output byte-0x20. Otherwise the byte passes unchanged.
- `mode` is sampled in the WR cycle.

FIFO:
- Circular buffer of DEPTH entries; pointers wrap modulo DEPTH.
- Full when count=DEPTH: the driver does not read, and the byte remains in the SPART.
- Empty when count=0: the driver never writes.
- Push and pop never occur in the same cycle.

Other rules:
- br_cfg change during LOAD_LO/LOAD_HI/RD/WR/GAP: no effect until the next IDLE, then a full reload.
- databus is never driven in RD, GAP, or IDLE. No cycle has both driver and SPART driving.

Test Plan:
- Reset release, br_cfg=01, CLK_HZ=100e6 -> cycle 1: ioaddr=10, data 0x8A; cycle 2: ioaddr=11, data 0x02; busy falls at GAP; iocs=0 in GAP.
- rda pulse, SPART drives 0x41, tbr=1, mode=0 -> RD cycle captures 0x41, fifo_count=1; after GAP, WR with ioaddr=00, databus=0x41; fifo_count=0.
- mode=1, received bytes 0x61, 0x7A, 0x7B, 0x31 -> transmitted 0x41, 0x5A, 0x7B, 0x31.
- tbr held 0, DEPTH=8, 10 rda events -> fifo_count saturates at 8; no RD cycle while full; after tbr=1, reads resume and all 10 bytes are transmitted in order.
- Both rda and tbr continuously high with FIFO non-empty -> accesses alternate RD, GAP, WR, GAP; neither starves.
- br_cfg 01->11 while 3 bytes are queued -> next IDLE issues loads 0xA1/0x00; fifo_count stays 3; echo then resumes. rst asserted during WR -> next cycle iocs=0, databus=Z, fifo_count=0.

Source files
------------

// File: rtl/spart_echo_driver.sv
// spart_echo_driver: SPART bus master that loads the baud divisor and
// echoes received bytes back through a FIFO, optionally upper-cased.
module spart_echo_driver #(
  parameter int CLK_HZ = 100000000,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       br_cfg,
  input  logic             mode,
  input  logic             rda,
  input  logic             tbr,
  output logic             iocs,
  output logic             iorw,
  output logic [1:0]       ioaddr,
  inout  wire  [7:0]       databus,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_LO   = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_IDLE = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;

  localparam logic [15:0] DIV0 = 16'(CLK_HZ / (16 * 4800) - 1);
  localparam logic [15:0] DIV1 = 16'(CLK_HZ / (16 * 9600) - 1);
  localparam logic [15:0] DIV2 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV3 = 16'(CLK_HZ / (16 * 38400) - 1);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // r_state is the access that the next edge will put on the bus
  logic [2:0]       r_state;
  logic             r_iocs;
  logic             r_iorw;
  logic [1:0]       r_addr;
  logic             r_busy;
  logic [1:0]       r_brq;
  logic             r_last_rd;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_dout;
  logic [7:0]       r_mem [DEPTH];

  logic [15:0] w_div;
  logic        w_rd_cyc;
  logic        w_wr_cyc;
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic [7:0]  w_head;
  logic [7:0]  w_xl;
  logic [7:0]  w_dout;

  // Divisor for the latched baud code
  always_comb begin
    w_div = DIV0;
    unique case (r_brq)
      2'b00: w_div = DIV0;
      2'b01: w_div = DIV1;
      2'b10: w_div = DIV2;
      2'b11: w_div = DIV3;
    endcase
  end

  assign w_rd_cyc = r_iocs & r_iorw;
  assign w_wr_cyc = r_iocs & ~r_iorw & (r_addr == 2'b00);
  assign w_rd_ok  = rda & (r_count != FULL);
  assign w_wr_ok  = tbr & (r_count != '0);

  assign w_head = r_mem[r_rptr];
  assign w_xl   = (mode && w_head >= 8'h61 && w_head <= 8'h7A)
                ? w_head - 8'h20 : w_head;
  assign w_dout = w_wr_cyc ? w_xl : r_dout;

  assign databus    = (r_iocs & ~r_iorw) ? w_dout : 8'hzz;
  assign iocs       = r_iocs;
  assign iorw       = r_iorw;
  assign ioaddr     = r_addr;
  assign fifo_count = r_count;
  assign busy       = r_busy;

  // Store the byte the SPART presents at the close of a read
  always_ff @(posedge clk) begin
    if (!rst && w_rd_cyc) r_mem[r_wptr] <= databus;
  end

  // Close the current access, then launch the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LO;
      r_iocs    <= 1'b0;
      r_iorw    <= 1'b1;
      r_addr    <= 2'b00;
      r_busy    <= 1'b1;
      r_brq     <= br_cfg;
      r_last_rd <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dout    <= 8'h00;
    end else begin
      if (w_rd_cyc) begin
        r_wptr    <= r_wptr + PTR_W'(1);
        r_count   <= r_count + CNT_W'(1);
        r_last_rd <= 1'b1;
      end
      if (w_wr_cyc) begin
        r_rptr    <= r_rptr + PTR_W'(1);
        r_count   <= r_count - CNT_W'(1);
        r_last_rd <= 1'b0;
      end
      r_iocs <= 1'b0;
      r_iorw <= 1'b1;
      r_addr <= 2'b00;
      r_busy <= 1'b0;
      unique case (r_state)
        S_LO: begin
          r_iocs  <= 1'b1;
          r_iorw  <= 1'b0;
          r_addr  <= 2'b10;
          r_dout  <= w_div[7:0];
          r_busy  <= 1'b1;
          r_state <= S_HI;
        end
        S_HI: begin
          r_iocs  <= 1'b1;
          r_iorw  <= 1'b0;
          r_addr  <= 2'b11;
          r_dout  <= w_div[15:8];
          r_busy  <= 1'b1;
          r_state <= S_GAP;
        end
        S_GAP: r_state <= S_IDLE;
        S_IDLE: begin
          if (br_cfg != r_brq) begin
            r_brq   <= br_cfg;
            r_state <= S_LO;
          end else if (w_rd_ok && (!w_wr_ok || !r_last_rd)) begin
            r_state <= S_RD;
          end else if (w_wr_ok) begin
            r_state <= S_WR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD: begin
          r_iocs  <= 1'b1;
          r_iorw  <= 1'b1;
          r_state <= S_GAP;
        end
        S_WR: begin
          r_iocs  <= 1'b1;
          r_iorw  <= 1'b0;
          r_state <= S_GAP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver: SPART stand-in plus queue model of the echo path.
// Random traffic is checked against the model; directed steps cover edges.
module tb_spart_echo_driver;

  localparam int CLK_HZ = 100000000;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       br_cfg = 2'b01;
  logic             mode = 1'b0;
  logic             rda = 1'b0;
  logic             tbr = 1'b0;
  logic             iocs;
  logic             iorw;
  logic [1:0]       ioaddr;
  wire  [7:0]       databus;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  logic       rst_q = 1'b1;
  logic       rda_en = 1'b0;
  logic [7:0] drv_byte = 8'h00;
  logic [15:0] mon_dv;
  logic [7:0] rx_q[$];
  logic [7:0] model_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] saved[$];
  int n_chk = 0;
  int n_err = 0;
  int rd_n = 0;
  int wr_n = 0;

  spart_echo_driver #(
    .CLK_HZ(CLK_HZ),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .mode      (mode),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .fifo_count(fifo_count),
    .busy      (busy)
  );

  assign databus = (iocs && iorw && ioaddr == 2'b00) ? drv_byte : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  function automatic logic [15:0] div_of(input logic [1:0] c);
    int baud;
    baud = 4800 << c;
    return 16'(CLK_HZ / (16 * baud) - 1);
  endfunction

  function automatic logic [7:0] up(input logic [7:0] b, input logic m);
    if (m && b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
    return b;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((rx_q.size() > 0 || model_q.size() > 0) && k < lim) begin
      @(posedge clk);
      k++;
    end
    cyc(3);
    chk("drain", rx_q.size() + model_q.size(), 0);
  endtask

  // SPART stand-in and per-cycle bus checks against the queue model
  always @(negedge clk) begin
    if (!rst_q) begin
      chk("count", int'(fifo_count), model_q.size());
      chk("busy", int'(busy), int'(iocs && !iorw && ioaddr[1]));
      mon_dv = div_of(br_cfg);
      if (iocs && !iorw && ioaddr == 2'b10)
        chk("div_lo", int'(databus), int'(mon_dv[7:0]));
      if (iocs && !iorw && ioaddr == 2'b11)
        chk("div_hi", int'(databus), int'(mon_dv[15:8]));
      if (iocs && iorw) begin
        chk("rd_room", int'(model_q.size() < DEPTH), 1);
        chk("rd_rda", int'(rx_q.size() > 0), 1);
        model_q.push_back(drv_byte);
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        rd_n++;
      end
      if (iocs && !iorw && ioaddr == 2'b00) begin
        if (model_q.size() == 0) begin
          chk("wr_empty", 0, 1);
        end else begin
          chk("tx", int'(databus), int'(up(model_q[0], mode)));
          tx_log.push_back(databus);
          void'(model_q.pop_front());
        end
        wr_n++;
      end
    end
    if (!(iocs && iorw)) drv_byte = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    rda = rda_en && (rx_q.size() > 0);
  end

  logic [7:0] tin [6] = '{8'h61, 8'h7A, 8'h7B, 8'h31, 8'h60, 8'h40};
  logic [7:0] tout[6] = '{8'h41, 8'h5A, 8'h7B, 8'h31, 8'h60, 8'h40};

  initial begin
    int n0;
    int r0;
    int w0;
    int d;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iocs", int'(iocs), 0);
    chk("rst_iorw", int'(iorw), 1);
    chk("rst_addr", int'(ioaddr), 0);
    chk("rst_cnt", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 1);
    chk("div_9600", int'(div_of(2'b01)), 16'h028A);

    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ld1_cs", int'(iocs), 1);
    chk("ld1_addr", int'(ioaddr), 2);
    chk("ld1_dat", int'(databus), 8'h8A);
    @(negedge clk);
    chk("ld2_addr", int'(ioaddr), 3);
    chk("ld2_dat", int'(databus), 8'h02);
    @(negedge clk);
    chk("gap_cs", int'(iocs), 0);
    chk("gap_busy", int'(busy), 0);

    cyc(1);
    mode = 1'b0;
    tbr = 1'b1;
    rda_en = 1'b1;
    n0 = tx_log.size();
    rx_q.push_back(8'h41);
    drain(60);
    chk("echo_n", tx_log.size() - n0, 1);
    if (tx_log.size() > n0) chk("echo_b", int'(tx_log[n0]), 8'h41);

    mode = 1'b1;
    n0 = tx_log.size();
    for (int i = 0; i < 6; i++) rx_q.push_back(tin[i]);
    drain(120);
    chk("up_n", tx_log.size() - n0, 6);
    for (int i = 0; i < 6; i++)
      if (tx_log.size() > n0 + i) chk("up_b", int'(tx_log[n0 + i]), int'(tout[i]));

    mode = 1'b0;
    tbr = 1'b0;
    saved.delete();
    for (int i = 0; i < 10; i++) begin
      saved.push_back(8'($urandom));
      rx_q.push_back(saved[i]);
    end
    cyc(80);
    chk("full_cnt", int'(fifo_count), DEPTH);
    chk("full_left", rx_q.size(), 2);
    n0 = tx_log.size();
    tbr = 1'b1;
    drain(200);
    chk("full_n", tx_log.size() - n0, 10);
    for (int i = 0; i < 10; i++)
      if (tx_log.size() > n0 + i) chk("order", int'(tx_log[n0 + i]), int'(saved[i]));

    for (int i = 0; i < 30; i++) rx_q.push_back(8'($urandom));
    r0 = rd_n;
    w0 = wr_n;
    cyc(60);
    d = (rd_n - r0) - (wr_n - w0);
    chk("alt_bal", int'(d == 0 || d == 1), 1);
    chk("alt_wr", int'((wr_n - w0) >= 8), 1);
    chk("alt_cnt", int'(fifo_count <= 1), 1);
    drain(200);

    tbr = 1'b0;
    for (int i = 0; i < 3; i++) rx_q.push_back(8'($urandom));
    cyc(20);
    chk("q3_cnt", int'(fifo_count), 3);
    br_cfg = 2'b11;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 12);
    chk("br_busy", int'(busy), 1);
    chk("br_lo", int'(databus), 8'hA1);
    chk("br_keep", int'(fifo_count), 3);
    @(negedge clk);
    chk("br_hi", int'(databus), 8'h00);
    cyc(1);
    tbr = 1'b1;
    drain(100);

    for (int i = 0; i < 600; i++) begin
      tbr = 1'($urandom_range(0, 1));
      rda_en = ($urandom_range(0, 3) != 0);
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3 && rx_q.size() < 20)
        rx_q.push_back(8'($urandom));
      cyc(1);
    end
    rda_en = 1'b1;
    tbr = 1'b1;
    drain(300);

    tbr = 1'b0;
    for (int i = 0; i < 3; i++) rx_q.push_back(8'($urandom));
    cyc(20);
    tbr = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(iocs && !iorw && ioaddr == 2'b00) && k < 20);
    chk("wr_seen", int'(iocs && !iorw && ioaddr == 2'b00), 1);
    rst = 1'b1;
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    chk("rwr_cs", int'(iocs), 0);
    chk("rwr_cnt", int'(fifo_count), 0);
    chk("rwr_busy", int'(busy), 1);
    cyc(2);
    rst = 1'b0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
